// File: rtl/ring_interlock_arbiter.sv
// Round-robin grant controller for an N-station ring interlock: one new grant per edge,
// ring-neighbour exclusion with post-release guard windows, and a per-grant watchdog.

module ring_station #(
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic win,
    input  logic req,
    input  logic fault_clr,
    output logic grant,
    output logic grant_next,
    output logic idle,
    output logic fault
);
    localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_GUARD} state_t;

    state_t        state;
    logic [GW-1:0] gcnt;
    logic [TW-1:0] timer;
    logic          rel;
    logic          timeout;

    // A release on the same edge as the timeout wins, so no fault is raised then.
    assign rel        = (state == ST_GRANTED) && !req;
    assign timeout    = (TIMEOUT_CYCLES != 0) && (state == ST_GRANTED) && req &&
                        (timer == TW'(TIMEOUT_CYCLES - 1));
    assign grant_next = ((state == ST_IDLE) && win) ||
                        ((state == ST_GRANTED) && !rel && !timeout);
    assign idle       = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gcnt  <= '0;
            timer <= '0;
            grant <= 1'b0;
            fault <= 1'b0;
        end else begin
            grant <= grant_next;
            if (timeout)
                fault <= 1'b1;
            else if (fault_clr)
                fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win) begin
                        state <= ST_GRANTED;
                        timer <= '0;
                    end
                end
                ST_GRANTED: begin
                    if (rel || timeout) begin
                        if (GUARD_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_GUARD;
                            gcnt  <= GW'(GUARD_CYCLES);
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_GUARD: begin
                    gcnt <= gcnt - GW'(1);
                    if (gcnt == GW'(1))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

module ring_interlock_arbiter #(
    parameter int N_STATIONS     = 8,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic [N_STATIONS-1:0]         i_req,
    input  logic                          i_fault_clr,
    output logic [N_STATIONS-1:0]         o_grant,
    output logic [N_STATIONS-1:0]         o_fault,
    output logic [$clog2(N_STATIONS)-1:0] o_ptr,
    output logic                          o_any_grant
);
    localparam int PW = $clog2(N_STATIONS);

    logic [N_STATIONS-1:0] idle;
    logic [N_STATIONS-1:0] elig;
    logic [N_STATIONS-1:0] win;
    logic [N_STATIONS-1:0] grant_next;
    logic [PW-1:0]         win_idx;
    logic                  found;

    for (genvar s = 0; s < N_STATIONS; s++) begin : g_st
        localparam int PREV = (s + N_STATIONS - 1) % N_STATIONS;
        localparam int NEXT = (s + 1) % N_STATIONS;

        assign elig[s] = idle[s] && i_req[s] && !o_fault[s] &&
                         idle[PREV] && idle[NEXT] && i_enable;

        ring_station #(
            .GUARD_CYCLES  (GUARD_CYCLES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_st (
            .clk       (i_clk),
            .rst_n     (i_rst_n),
            .win       (win[s]),
            .req       (i_req[s]),
            .fault_clr (i_fault_clr),
            .grant     (o_grant[s]),
            .grant_next(grant_next[s]),
            .idle      (idle[s]),
            .fault     (o_fault[s])
        );
    end

    // First eligible station at or after the pointer, wrapping around the ring.
    always_comb begin
        int idx;
        found   = 1'b0;
        win_idx = '0;
        win     = '0;
        for (int i = 0; i < N_STATIONS; i++) begin
            idx = (int'(o_ptr) + i) % N_STATIONS;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                win_idx = PW'(idx);
            end
        end
        if (found)
            win[win_idx] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ptr       <= '0;
            o_any_grant <= 1'b0;
        end else begin
            o_any_grant <= |grant_next;
            if (found)
                o_ptr <= (win_idx == PW'(N_STATIONS - 1)) ? '0 : win_idx + PW'(1);
        end
    end
endmodule

// File: tb/tb_ring_interlock_arbiter.sv
// Directed bench: one instance with a 4-cycle guard and 16-cycle watchdog, one with zero
// guard and no watchdog; both share inputs and are checked for neighbour exclusion.

module tb_ring_interlock_arbiter;
    logic       clk = 0, rst_n = 1, enable = 1, fault_clr = 0;
    logic [7:0] req = '0;
    logic [7:0] grant, fault, grant0, fault0;
    logic [2:0] ptr, ptr0;
    logic       any, any0;
    int         n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    ring_interlock_arbiter #(.N_STATIONS(8), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_req(req), .i_fault_clr(fault_clr),
        .o_grant(grant), .o_fault(fault), .o_ptr(ptr), .o_any_grant(any));

    ring_interlock_arbiter #(.N_STATIONS(8), .GUARD_CYCLES(0), .TIMEOUT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_req(req), .i_fault_clr(fault_clr),
        .o_grant(grant0), .o_fault(fault0), .o_ptr(ptr0), .o_any_grant(any0));

    // Ring exclusion and any_grant coherence on both instances, every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            if ((grant & {grant[0], grant[7:1]}) != 0 || (grant0 & {grant0[0], grant0[7:1]}) != 0) begin
                n_fail++;
                $display("FAIL exclusion: grant=%b grant0=%b", grant, grant0);
            end
            n_tests++;
            if (any !== (|grant) || any0 !== (|grant0)) begin
                n_fail++;
                $display("FAIL any_grant: any=%b grant=%b any0=%b grant0=%b", any, grant, any0, grant0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] r);
        @(posedge clk);
        #3;
        rst_n = 0;
        req = r; enable = 1; fault_clr = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #2;
        n_tests++;
        if (grant !== 0 || fault !== 0 || ptr !== 0 || any !== 0 ||
            grant0 !== 0 || fault0 !== 0 || ptr0 !== 0 || any0 !== 0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%h fault=%h ptr=%0d any=%b, required all 0", grant, fault, ptr, any);
        end
        step();
        rst_n = 1;
    endtask

    task automatic test_basic();
        do_reset(8'h00);
        req = 8'h01;
        step();
        n_tests++;
        if (grant !== 8'h01 || ptr !== 3'd1 || any !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_grant: grant=%h ptr=%0d any=%b, required 01/1/1", grant, ptr, any);
        end
        req = 8'h00;
        step();
        n_tests++;
        if (grant !== 8'h00 || any !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: grant=%h any=%b, required 00/0", grant, any);
        end
        req = 8'h02;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_tests++;
            if (grant !== 8'h00) begin
                n_fail++;
                $display("FAIL basic_guard_block: edge r+%0d grant=%h, required 00", i, grant);
            end
        end
        step();
        n_tests++;
        if (grant !== 8'h02 || ptr !== 3'd2) begin
            n_fail++;
            $display("FAIL basic_neighbour_grant: grant=%h ptr=%0d, required 02/2", grant, ptr);
        end
    endtask

    task automatic test_all_requesting();
        logic [7:0] exp_g [4] = '{8'h01, 8'h05, 8'h15, 8'h55};
        logic [2:0] exp_p [4] = '{3'd1, 3'd3, 3'd5, 3'd7};
        do_reset(8'hFF);
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (grant !== exp_g[i] || ptr !== exp_p[i]) begin
                n_fail++;
                $display("FAIL all_seq[%0d]: grant=%h ptr=%0d, required %h/%0d", i, grant, ptr, exp_g[i], exp_p[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (grant !== 8'h55 || ptr !== 3'd7) begin
                n_fail++;
                $display("FAIL all_hold[%0d]: grant=%h ptr=%0d, required 55/7", i, grant, ptr);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset(8'h00);
        req = 8'h10;
        step();
        n_tests++;
        if (grant !== 8'h10 || ptr !== 3'd5) begin
            n_fail++;
            $display("FAIL rr_setup: grant=%h ptr=%0d, required 10/5", grant, ptr);
        end
        req = 8'h44;
        step();
        n_tests++;
        if (grant !== 8'h40 || ptr !== 3'd7) begin
            n_fail++;
            $display("FAIL rr_winner: grant=%h ptr=%0d, required 40/7", grant, ptr);
        end
        step();
        n_tests++;
        if (grant !== 8'h44 || ptr !== 3'd3) begin
            n_fail++;
            $display("FAIL rr_next: grant=%h ptr=%0d, required 44/3", grant, ptr);
        end
    endtask

    task automatic test_watchdog();
        do_reset(8'h00);
        req = 8'h08;
        step();
        n_tests++;
        if (grant !== 8'h08) begin
            n_fail++;
            $display("FAIL wd_grant: grant=%h, required 08", grant);
        end
        for (int i = 1; i <= 15; i++) begin
            step();
            n_tests++;
            if (grant !== 8'h08 || fault !== 8'h00) begin
                n_fail++;
                $display("FAIL wd_hold[%0d]: grant=%h fault=%h, required 08/00", i, grant, fault);
            end
        end
        step();
        n_tests++;
        if (grant !== 8'h00 || fault !== 8'h08) begin
            n_fail++;
            $display("FAIL wd_timeout: grant=%h fault=%h, required 00/08", grant, fault);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if (grant !== 8'h00 || fault !== 8'h08) begin
                n_fail++;
                $display("FAIL wd_blocked[%0d]: grant=%h fault=%h, required 00/08", i, grant, fault);
            end
        end
        fault_clr = 1;
        step();
        fault_clr = 0;
        n_tests++;
        if (fault !== 8'h00 || grant !== 8'h00) begin
            n_fail++;
            $display("FAIL wd_clear: fault=%h grant=%h, required 00/00", fault, grant);
        end
        step();
        n_tests++;
        if (grant !== 8'h08 || ptr !== 3'd4) begin
            n_fail++;
            $display("FAIL wd_regrant: grant=%h ptr=%0d, required 08/4", grant, ptr);
        end
        for (int i = 1; i <= 15; i++) step();
        fault_clr = 1;
        step();
        fault_clr = 0;
        n_tests++;
        if (fault !== 8'h08 || grant !== 8'h00) begin
            n_fail++;
            $display("FAIL wd_set_wins: fault=%h grant=%h, required 08/00", fault, grant);
        end
        n_tests++;
        if (grant0 !== 8'h08 || fault0 !== 8'h00) begin
            n_fail++;
            $display("FAIL wd_disabled: grant0=%h fault0=%h, required 08/00", grant0, fault0);
        end
    endtask

    task automatic test_enable_reset();
        req = 8'h01;
        step();
        n_tests++;
        if (grant !== 8'h01 || ptr !== 3'd1) begin
            n_fail++;
            $display("FAIL en_setup: grant=%h ptr=%0d, required 01/1", grant, ptr);
        end
        enable = 0;
        req = 8'h41;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (grant !== 8'h01 || ptr !== 3'd1) begin
                n_fail++;
                $display("FAIL en_low[%0d]: grant=%h ptr=%0d, required 01/1", i, grant, ptr);
            end
        end
        enable = 1;
        step();
        n_tests++;
        if (grant !== 8'h41 || ptr !== 3'd7 || fault !== 8'h08) begin
            n_fail++;
            $display("FAIL en_resume: grant=%h ptr=%0d fault=%h, required 41/7/08", grant, ptr, fault);
        end
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        n_tests++;
        if (grant !== 8'h00 || fault !== 8'h00 || ptr !== 3'd0 || any !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: grant=%h fault=%h ptr=%0d any=%b, required 00/00/0/0", grant, fault, ptr, any);
        end
        req = 8'h00;
        step();
        rst_n = 1;
    endtask

    task automatic test_zero_guard();
        do_reset(8'h00);
        req = 8'h80;
        step();
        n_tests++;
        if (grant0 !== 8'h80 || ptr0 !== 3'd0) begin
            n_fail++;
            $display("FAIL zg_wrap: grant0=%h ptr0=%0d, required 80/0", grant0, ptr0);
        end
        req = 8'h01;
        step();
        n_tests++;
        if (grant0 !== 8'h00 || ptr0 !== 3'd0) begin
            n_fail++;
            $display("FAIL zg_release: grant0=%h ptr0=%0d, required 00/0", grant0, ptr0);
        end
        step();
        n_tests++;
        if (grant0 !== 8'h01 || ptr0 !== 3'd1) begin
            n_fail++;
            $display("FAIL zg_neighbour: grant0=%h ptr0=%0d, required 01/1", grant0, ptr0);
        end
        n_tests++;
        if (grant !== 8'h00) begin
            n_fail++;
            $display("FAIL zg_guarded_contrast: grant=%h, required 00", grant);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_requesting();
        test_round_robin();
        test_watchdog();
        test_enable_reset();
        test_zero_guard();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
